// File: rtl/iter_divider_if.sv
// iter_divider_if: request/response channel between the execute stage (master) and iter_divider (slave).
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       div_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             busy;
  modport master (
    output req_valid, div_op, src1, src2, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );
  modport slave (
    input  req_valid, div_op, src1, src2, flush, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish zero-divisor and |dividend| < |divisor| cases without iterating.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  iter_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic sgn, is_mod, neg1, neg2;
  logic [WIDTH-1:0] raw1, dvs, rem, quo, res;
  logic [CW-1:0] cnt;
  logic sgn_in, mod_in, acc, last, early, dz, ge;
  logic [WIDTH-1:0] mag1, mag2, rem_n, quo_n, q_fix, r_fix, early_res;
  logic [WIDTH:0] r_sh;
  assign sgn_in = |(bus.div_op & 4'b0011);
  assign mod_in = |(bus.div_op & 4'b1010);
  assign mag1 = (sgn_in && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
  assign mag2 = (sgn_in && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  assign bus.req_ready = !rst && state == IDLE && !bus.flush;
  assign acc = bus.req_valid && bus.req_ready;
  assign last = cnt == CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
  assign early = mag2 == '0 || mag1 < mag2;
`else
  assign early = 1'b0;
`endif
  assign early_res = mod_in ? bus.src1 : {WIDTH{mag2 == '0}};
  // Shift the next dividend bit into the partial remainder; subtract only when it fits.
  assign r_sh = {rem, quo[WIDTH-1]};
  assign ge = r_sh >= {1'b0, dvs};
  assign rem_n = ge ? r_sh[WIDTH-1:0] - dvs : r_sh[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ge};
  // Zero divisor is forced so signed ops return all-ones / original dividend regardless of signs.
  assign dz = dvs == '0;
  assign q_fix = dz ? '1 : (sgn && (neg1 != neg2)) ? -quo_n : quo_n;
  assign r_fix = dz ? raw1 : (sgn && neg1) ? -rem_n : rem_n;
  assign bus.resp_valid = state == DONE;
  assign bus.resp_result = res;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = acc ? (early ? DONE : CALC) : IDLE;
      CALC: state_n = bus.flush ? IDLE : last ? DONE : CALC;
      DONE: state_n = (bus.flush || bus.resp_ready) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn <= 1'b0;
      is_mod <= 1'b0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      raw1 <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      res <= '0;
      cnt <= '0;
    end else if (acc) begin
      sgn <= sgn_in;
      is_mod <= mod_in;
      neg1 <= bus.src1[WIDTH-1];
      neg2 <= bus.src2[WIDTH-1];
      raw1 <= bus.src1;
      dvs <= mag2;
      quo <= mag1;
      rem <= '0;
      cnt <= '0;
      if (early) res <= early_res;
    end else if (state == CALC) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
      if (last) res <= is_mod ? r_fix : q_fix;
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed vectors for iter_divider; honours DIV_EARLY_OUT_EN for expected latency.
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int errors = 0;
  int n;
  logic seen;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  iter_divider_if #(.WIDTH(32)) bus ();
  iter_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic start(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.div_op = o;
    bus.src1 = a;
    bus.src2 = b;
    #1 check("req_ready_idle", 32'(bus.req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic bad;
    bad = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 100) begin
      bad |= bus.req_ready;
      @(negedge clk);
      cyc++;
    end
    check("req_ready_busy", 32'(bad | bus.req_ready), 0);
  endtask

  task automatic op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] r, input bit e, input int hold);
    int cyc;
    start(o, a, b);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, (EARLY && e) ? 1 : 33);
    check(tag, bus.resp_result, r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.resp_valid), 1);
      check("hold_result", bus.resp_result, r);
      check("hold_ready", 32'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("valid_drop", 32'(bus.resp_valid), 0);
    #1 check("ready_after", 32'(bus.req_ready), 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.div_op = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.resp_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_result", bus.resp_result, 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    #1 check("ready_out_of_rst", 32'(bus.req_ready), 1);
    @(negedge clk);
    op("divw_7_m2",     4'b0001, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 0);
    op("modw_7_m2",     4'b0010, 32'd7,          32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    op("divwu_ff_10",   4'b0100, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 1'b0, 0);
    op("modwu_ff_10",   4'b1000, 32'hFFFFFFFF,   32'h10,       32'h0000000F, 1'b0, 5);
    op("divw_dz",       4'b0001, 32'h12345678,   32'h0,        32'hFFFFFFFF, 1'b1, 0);
    op("modw_dz",       4'b0010, 32'h12345678,   32'h0,        32'h12345678, 1'b1, 0);
    op("divwu_dz",      4'b0100, 32'h12345678,   32'h0,        32'hFFFFFFFF, 1'b1, 0);
    op("modwu_dz",      4'b1000, 32'h12345678,   32'h0,        32'h12345678, 1'b1, 0);
    op("divw_dz_neg",   4'b0001, 32'h80000001,   32'h0,        32'hFFFFFFFF, 1'b1, 0);
    op("modw_dz_neg",   4'b0010, 32'h80000001,   32'h0,        32'h80000001, 1'b1, 0);
    op("divw_ovf",      4'b0001, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b0, 0);
    op("modw_ovf",      4'b0010, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b0, 0);
    op("divw_m7_2",     4'b0001, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0, 0);
    op("modw_m7_2",     4'b0010, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0, 0);
    op("divw_m3_7",     4'b0001, 32'hFFFFFFFD,   32'd7,        32'h00000000, 1'b1, 0);
    op("modw_m3_7",     4'b0010, 32'hFFFFFFFD,   32'd7,        32'hFFFFFFFD, 1'b1, 0);
    // Flush on the 10th CALC cycle: no response, idle right after.
    start(4'b0100, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 check("flush_calc_ready", 32'(bus.req_ready), 1);
    check("flush_calc_busy", 32'(bus.busy), 0);
    seen = bus.resp_valid;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    check("flush_calc_novalid", 32'(seen), 0);
    op("divwu_100_7",   4'b0100, 32'd100,        32'd7,        32'h0000000E, 1'b0, 0);
    // Flush in IDLE blocks acceptance.
    bus.req_valid = 1'b1;
    bus.div_op = 4'b0100;
    bus.flush = 1'b1;
    #1 check("flush_idle_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check("flush_idle_busy", 32'(bus.busy), 0);
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    // Flush together with resp_ready in DONE discards the result.
    start(4'b0100, 32'd50, 32'd5);
    wait_done(n);
    check("done_reached", 32'(bus.resp_valid), 1);
    bus.flush = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    check("flush_done_valid", 32'(bus.resp_valid), 0);
    check("flush_done_busy", 32'(bus.busy), 0);
    op("modwu_100_7",   4'b1000, 32'd100,        32'd7,        32'h00000002, 1'b0, 0);
    // Reset mid-operation discards it.
    start(4'b0001, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_valid", 32'(bus.resp_valid), 0);
    check("rst_mid_result", bus.resp_result, 0);
    @(negedge clk);
    op("divwu_3_7",     4'b0100, 32'd3,          32'd7,        32'h00000000, 1'b1, 0);
    op("modwu_3_7",     4'b1000, 32'd3,          32'd7,        32'h00000003, 1'b1, 0);
    op("divw_1000_3",   4'b0001, 32'd1000,       32'd3,        32'd333,      1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
